// File: rtl/iso7816_rx_char.sv
// ISO 7816-3 T=0 character receiver: start + 8 data + even parity, with
// optional error signal (I/O pulled low for one etu) on parity failure.
module iso7816_rx_char (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       cfg_inverse,
  input  logic       cfg_err_ena,
  input  logic       io_i,
  output logic       io_oe,
  output logic       brg_sync,
  output logic       brg_run,
  output logic       brg_txrx,
  input  logic       stb_rx,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_stb
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, GUARD, ERR, RECOV
  } state_t;

  state_t     state, state_nxt;
  logic       sync1, sync2, hist;
  logic       fall, bit_l;
  logic [2:0] cnt;
  logic [7:0] shreg;
  logic       par, perr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= io_i;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign fall     = hist & ~sync2;
  assign bit_l    = sync2 ^ cfg_inverse;
  assign brg_run  = (state != IDLE);
  assign brg_txrx = 1'b0;

  always_comb begin
    state_nxt = state;
    brg_sync  = 1'b0;
    if (!ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // a fall takes priority over any stb_rx arriving in the same cycle
          if (fall) begin
            brg_sync  = 1'b1;
            state_nxt = START;
          end
        end
        START:  if (stb_rx) state_nxt = sync2 ? IDLE : DATA;
        DATA:   if (stb_rx && cnt == 3'd7) state_nxt = PARITY;
        PARITY: if (stb_rx) state_nxt = GUARD;
        GUARD:  if (stb_rx) state_nxt = (perr_q && cfg_err_ena) ? ERR : IDLE;
        ERR:    if (stb_rx) state_nxt = RECOV;
        RECOV:  if (stb_rx) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      perr_q  <= 1'b0;
      rx_data <= '0;
      rx_perr <= 1'b0;
      rx_stb  <= 1'b0;
      io_oe   <= 1'b0;
    end else begin
      state  <= state_nxt;
      // registered from the next state so io_oe is high exactly while in ERR
      io_oe  <= (state_nxt == ERR);
      rx_stb <= 1'b0;
      if (ena && stb_rx) begin
        case (state)
          START: begin
            cnt <= '0;
            par <= 1'b0;
          end
          DATA: begin
            shreg <= cfg_inverse ? {shreg[6:0], bit_l} : {bit_l, shreg[7:1]};
            par   <= par ^ bit_l;
            if (cnt != 3'd7) cnt <= cnt + 3'd1;
          end
          PARITY: begin
            perr_q  <= par ^ bit_l;
            rx_data <= shreg;
            rx_perr <= par ^ bit_l;
            rx_stb  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
